// File: rtl/prim_sequencer.sv
// Command front-end for the bresenline rasterizer: expands line, triangle and rectangle
// commands into ordered segments and hands them out one at a time.
module prim_sequencer #(
   parameter int unsigned H_RES = 640,
   parameter int unsigned V_RES = 480
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_type,
   input  logic [18:0] cmd_v0,
   input  logic [18:0] cmd_v1,
   input  logic [18:0] cmd_v2,
   output logic [37:0] positions,
   output logic        primSelect,
   input  logic        lineDone,
   output logic        busy,
   output logic        primDone,
   output logic        err
);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

   localparam logic [9:0] XMax     = 10'(H_RES - 1);
   localparam logic [8:0] YMax     = 9'(V_RES - 1);
   localparam logic [1:0] TypeTri  = 2'b01;
   localparam logic [1:0] TypeRect = 2'b10;
   localparam logic [1:0] TypeRsvd = 2'b11;

   state_e      state_q;
   logic [1:0]  seg_q;
   logic [1:0]  type_q;
   logic [18:0] v0_q, v1_q, v2_q;
   logic        line_done_q;

   function automatic logic [18:0] clamp(input logic [18:0] v);
      logic [9:0] x;
      logic [8:0] y;
      x = (v[18:9] > XMax) ? XMax : v[18:9];
      y = (v[8:0] > YMax) ? YMax : v[8:0];
      return {x, y};
   endfunction

   logic [18:0] in_v0, in_v1, in_v2;
   assign in_v0 = clamp(cmd_v0);
   assign in_v1 = clamp(cmd_v1);
   assign in_v2 = clamp(cmd_v2);

   logic [1:0]  sel_type, sel_seg, last_seg;
   logic [18:0] s0, s1, s2;
   logic [37:0] seg_pos;
   logic        line_rise;

   // Segment to load on the next ISSUE entry: first segment of the incoming command when idle,
   // otherwise the segment after the current one from the latched copy.
   always_comb begin
      sel_type = type_q;
      sel_seg  = seg_q + 2'd1;
      s0       = v0_q;
      s1       = v1_q;
      s2       = v2_q;
      if (state_q == StIdle) begin
         sel_type = cmd_type;
         sel_seg  = 2'd0;
         s0       = in_v0;
         s1       = in_v1;
         s2       = in_v2;
      end
      seg_pos = {s0, s1};
      case (sel_type)
         TypeTri: begin
            case (sel_seg)
               2'd0:    seg_pos = {s0, s1};
               2'd1:    seg_pos = {s1, s2};
               default: seg_pos = {s2, s0};
            endcase
         end
         TypeRect: begin
            case (sel_seg)
               2'd0:    seg_pos = {s0[18:9], s0[8:0], s1[18:9], s0[8:0]};
               2'd1:    seg_pos = {s1[18:9], s0[8:0], s1[18:9], s1[8:0]};
               2'd2:    seg_pos = {s1[18:9], s1[8:0], s0[18:9], s1[8:0]};
               default: seg_pos = {s0[18:9], s1[8:0], s0[18:9], s0[8:0]};
            endcase
         end
         default: seg_pos = {s0, s1};
      endcase
   end

   always_comb begin
      case (type_q)
         TypeTri:  last_seg = 2'd2;
         TypeRect: last_seg = 2'd3;
         default:  last_seg = 2'd0;
      endcase
   end

   assign line_rise = lineDone & ~line_done_q;
   assign cmd_ready = (state_q == StIdle);
   assign busy      = (state_q != StIdle);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q     <= StIdle;
         seg_q       <= 2'd0;
         type_q      <= 2'd0;
         v0_q        <= '0;
         v1_q        <= '0;
         v2_q        <= '0;
         line_done_q <= 1'b0;
         positions   <= '0;
         primSelect  <= 1'b0;
         primDone    <= 1'b0;
         err         <= 1'b0;
      end else begin
         line_done_q <= lineDone;
         primSelect  <= 1'b0;
         primDone    <= 1'b0;
         err         <= 1'b0;
         case (state_q)
            StIdle: begin
               if (cmd_valid) begin
                  type_q <= cmd_type;
                  v0_q   <= in_v0;
                  v1_q   <= in_v1;
                  v2_q   <= in_v2;
                  seg_q  <= 2'd0;
                  if (cmd_type == TypeRsvd) begin
                     err <= 1'b1;
                  end else begin
                     positions  <= seg_pos;
                     primSelect <= 1'b1;
                     state_q    <= StIssue;
                  end
               end
            end
            StIssue: state_q <= StWait;
            StWait: begin
               if (line_rise) begin
                  if (seg_q == last_seg) begin
                     primDone <= 1'b1;
                     state_q  <= StDone;
                  end else begin
                     seg_q      <= seg_q + 2'd1;
                     positions  <= seg_pos;
                     primSelect <= 1'b1;
                     state_q    <= StIssue;
                  end
               end
            end
            StDone:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_prim_sequencer.sv
// Randomized scoreboard bench for prim_sequencer with a mock bresenline responder.
module tb_prim_sequencer;

   logic        tb_clk = 1'b0;
   logic        n_rst;
   logic        cmd_valid, cmd_ready;
   logic [1:0]  cmd_type;
   logic [18:0] cmd_v0, cmd_v1, cmd_v2;
   logic [37:0] positions;
   logic        primSelect, lineDone, busy, primDone, err;

   always #5 tb_clk = ~tb_clk;

   prim_sequencer #(.H_RES(640), .V_RES(480)) dut (
      .clk        (tb_clk),
      .n_rst      (n_rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_type   (cmd_type),
      .cmd_v0     (cmd_v0),
      .cmd_v1     (cmd_v1),
      .cmd_v2     (cmd_v2),
      .positions  (positions),
      .primSelect (primSelect),
      .lineDone   (lineDone),
      .busy       (busy),
      .primDone   (primDone),
      .err        (err)
   );

   int          errors = 0;
   int          checks = 0;
   logic [37:0] exp_q[$];
   int          pending_done = 0;
   int          pending_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [18:0] clampv(input logic [18:0] v);
      int x, y;
      x = int'(v[18:9]);
      y = int'(v[8:0]);
      if (x > 639) x = 639;
      if (y > 479) y = 479;
      return {10'(x), 9'(y)};
   endfunction

   // Reference: a primitive is a closed (or open, for a line) polyline of clamped corners.
   task automatic push_expected(input logic [1:0] t, input logic [18:0] a, input logic [18:0] b,
                                input logic [18:0] c, output int nseg);
      logic [18:0] p[$];
      logic [18:0] ca, cb, cc;
      ca = clampv(a);
      cb = clampv(b);
      cc = clampv(c);
      if (t == 2'd0) begin
         p.push_back(ca); p.push_back(cb);
      end else if (t == 2'd1) begin
         p.push_back(ca); p.push_back(cb); p.push_back(cc); p.push_back(ca);
      end else begin
         p.push_back(ca);
         p.push_back({cb[18:9], ca[8:0]});
         p.push_back(cb);
         p.push_back({ca[18:9], cb[8:0]});
         p.push_back(ca);
      end
      nseg = p.size() - 1;
      for (int i = 0; i < nseg; i++) exp_q.push_back({p[i], p[i+1]});
   endtask

   // Monitor: pops the scoreboard whenever the DUT issues a segment or completes.
   always @(negedge tb_clk) begin
      logic [37:0] e;
      if (n_rst === 1'b1) begin
         check("ready_vs_busy", cmd_ready, !busy);
         if (primSelect === 1'b1) begin
            if (exp_q.size() == 0) check("spurious_primSelect", 1, 0);
            else begin
               e = exp_q.pop_front();
               check("positions", positions, e);
            end
         end
         if (primDone === 1'b1) begin
            check("primDone_expected", (pending_done > 0) && (exp_q.size() == 0), 1);
            if (pending_done > 0) pending_done--;
         end
         if (err === 1'b1) begin
            check("err_expected", pending_err > 0, 1);
            if (pending_err > 0) pending_err--;
         end
      end
   end

   task automatic check_reset_values();
      check("rst_positions", positions, 0);
      check("rst_primSelect", primSelect, 0);
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_primDone", primDone, 0);
      check("rst_err", err, 0);
   endtask

   // Issue one command and play bresenline: lineDone held for h cycles per segment.
   task automatic run_prim(input logic [1:0] t, input logic [18:0] a, input logic [18:0] b,
                           input logic [18:0] c, input int h, input int reset_at);
      int n, nseg, d;
      bit last;
      n = 0;
      while (cmd_ready !== 1'b1 && n < 50) begin
         @(negedge tb_clk);
         n++;
      end
      check("ready_before_cmd", cmd_ready, 1);
      nseg = 0;
      if (t == 2'd3) pending_err++;
      else begin
         push_expected(t, a, b, c, nseg);
         pending_done++;
      end
      cmd_valid = 1'b1;
      cmd_type  = t;
      cmd_v0    = a;
      cmd_v1    = b;
      cmd_v2    = c;
      @(negedge tb_clk);
      cmd_valid = 1'b0;
      if (t == 2'd3) begin
         check("err_pulse", err, 1);
         check("no_issue_on_err", primSelect, 0);
         check("ready_after_err", cmd_ready, 1);
         return;
      end
      check("issue_latency", primSelect, 1);
      for (int s = 0; s < nseg; s++) begin
         last = (s == nseg - 1);
         if (s == reset_at) begin
            @(negedge tb_clk);
            n_rst = 1'b0;
            #1;
            check_reset_values();
            exp_q.delete();
            pending_done = 0;
            repeat (3) begin
               @(negedge tb_clk);
               check("no_done_in_reset", primDone, 0);
            end
            n_rst = 1'b1;
            return;
         end
         d = $urandom_range(1, 3);
         repeat (d) begin
            // Junk commands while busy must not disturb the latched primitive.
            cmd_valid = 1'($urandom);
            cmd_type  = 2'($urandom);
            cmd_v0    = 19'($urandom);
            cmd_v1    = 19'($urandom);
            cmd_v2    = 19'($urandom);
            @(negedge tb_clk);
            check("busy_while_wait", busy, 1);
            check("stall_no_advance", primSelect | primDone, 0);
         end
         cmd_valid = 1'b0;
         lineDone  = 1'b1;
         @(negedge tb_clk);
         if (last) check("done_latency", primDone, 1);
         else check("advance_latency", primSelect, 1);
         for (int k = 1; k < h; k++) begin
            @(negedge tb_clk);
            check("level_single_advance", primSelect | primDone, 0);
            if (last && k == 1) check("ready_after_done", cmd_ready, 1);
         end
         if (last && h == 1) begin
            @(negedge tb_clk);
            check("ready_after_done", cmd_ready, 1);
         end
         lineDone = 1'b0;
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      cmd_valid = 1'b0;
      cmd_type  = 2'd0;
      cmd_v0    = '0;
      cmd_v1    = '0;
      cmd_v2    = '0;
      lineDone  = 1'b0;
      n_rst     = 1'b1;
      #2 n_rst  = 1'b0;
      #1;
      check_reset_values();
      @(negedge tb_clk);
      @(negedge tb_clk);
      n_rst = 1'b1;
      @(negedge tb_clk);

      run_prim(2'd0, {10'd0, 9'd0}, {10'd640, 9'd480}, 19'd0, 1, -1);
      check("line_clamp_hold", positions, {10'd0, 9'd0, 10'd639, 9'd479});
      run_prim(2'd1, {10'd10, 9'd10}, {10'd100, 9'd20}, {10'd50, 9'd200}, 1, -1);
      run_prim(2'd2, {10'd5, 9'd5}, {10'd20, 9'd30}, 19'($urandom), 2, -1);
      check("rect_last_hold", positions, {10'd5, 9'd30, 10'd5, 9'd5});
      run_prim(2'd3, 19'($urandom), 19'($urandom), 19'($urandom), 1, -1);
      run_prim(2'd1, {10'd700, 9'd3}, {10'd1, 9'd500}, {10'd320, 9'd240}, 10, -1);
      run_prim(2'd1, {10'd1, 9'd2}, {10'd3, 9'd4}, {10'd5, 9'd6}, 1, 1);
      check("positions_after_reset", positions, 0);
      run_prim(2'd0, {10'd7, 9'd8}, {10'd7, 9'd8}, 19'd0, 1, -1);

      for (int i = 0; i < 60; i++) begin
         run_prim(2'($urandom_range(0, 3)), 19'($urandom), 19'($urandom), 19'($urandom),
                  $urandom_range(1, 4), -1);
      end

      repeat (4) @(negedge tb_clk);
      check("scoreboard_drained", exp_q.size(), 0);
      check("done_drained", pending_done, 0);
      check("err_drained", pending_err, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/prim_sequencer.md
# prim_sequencer

Upstream command stage for the `bresenline` rasterizer. Accepts one primitive command per handshake and expands it into an ordered series of line segments:
- line: 1 segment
- triangle: 3 segments
- rectangle: 4 segments

For each segment it drives the packed `positions` bus and a `primSelect` pulse into `bresenline`, then waits for that line to finish before issuing the next. It reports completion of the whole primitive to the command source.

## Interface
- `H_RES`, 640: horizontal resolution; x coordinates clamp to `H_RES-1`.
- `V_RES`, 480: vertical resolution; y coordinates clamp to `V_RES-1`.

Ports:
- `clk` in 1: single system clock; all state updates on the rising edge.
- `n_rst` in 1: reset, asynchronous and active-low.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: high only in IDLE. A command is accepted on an edge where `cmd_valid && cmd_ready`.
- `cmd_type` in 2: command type.
  - 00 = line
  - 01 = triangle
  - 10 = rectangle
  - 11 = reserved
- `cmd_v0`, `cmd_v1`, `cmd_v2` in 19 each: vertices packed as {x[9:0], y[8:0]}.
- `positions` out 38: segment endpoints packed as {x0[9:0], y0[8:0], x1[9:0], y1[8:0]}, routed to `bresenline.positions`.
- `primSelect` out 1: one-cycle start pulse to `bresenline`.
- `lineDone` in 1: completion indication from `bresenline`; may arrive as a pulse or a level.
- `busy` out 1: high from acceptance through the DONE cycle.
- `primDone` out 1: one-cycle pulse when the last segment of the primitive completes.
- `err` out 1: one-cycle pulse when a reserved command type is accepted.

## Operation
**Acceptance**
- On acceptance, all three vertices are clamped (x > `H_RES-1` → `H_RES-1`; y > `V_RES-1` → `V_RES-1`) and latched together with `cmd_type`.
- `cmd_*` inputs are ignored while `cmd_ready` is low.

**Segment lists** (segment counter `seg` is 2 bits, reset to 0 on each acceptance)
- Line: v0→v1.
- Triangle: v0→v1, v1→v2, v2→v0.
- Rectangle: corners A=(x0,y0), B=(x1,y0), C=(x1,y1), D=(x0,y1); segments A→B, B→C, C→D, D→A. `cmd_v2` is ignored.
- Degenerate segments (start point equals end point) are still issued.

**State machine** (states IDLE, ISSUE, WAIT, DONE)
- IDLE: `cmd_ready`=1.
  - Accepted valid type → ISSUE.
  - Accepted reserved type → stays IDLE and pulses `err` in the following cycle. No segment is issued and there is no `primDone`.
- ISSUE: `positions` is registered to segment `seg`, and `primSelect`=1 for exactly this cycle. Always → WAIT.
- WAIT: holds until a rising edge of `lineDone` is detected (`lineDone`=1 and its registered previous value = 0).
  - If `seg` is the last segment → DONE.
  - Otherwise `seg`+1 → ISSUE.
- DONE: `primDone`=1 for one cycle. Always → IDLE.

**Output behaviour**
- `positions` holds its last value in every state other than ISSUE, including IDLE.
- A `lineDone` held high across several cycles counts as one completion.
- A `lineDone` edge arriving in ISSUE is recorded by the edge register but does not advance the state. Only edges seen in WAIT advance the state.

## Timing
**Reset values:** `positions`=0, `primSelect`=0, `cmd_ready`=1, `busy`=0, `primDone`=0, `err`=0, `seg`=0, state=IDLE, `lineDone` history register=0.

**Reset mid-operation:** asserting `n_rst` in any state returns the block to IDLE with the reset values above. The in-flight primitive is discarded and gets no `primDone`.

**Latencies:**
- Acceptance edge → `primSelect` high in the next cycle (1 cycle).
- `lineDone` rising edge sampled at edge E:
  - next segment's `primSelect` is high in the cycle after E, or
  - `primDone` is high in the cycle after E if that was the last segment.
- `cmd_ready` returns high the cycle after the `primDone` cycle.

**Minimum cycles per primitive:** with `bresenline` returning `lineDone` one cycle after `primSelect`, a line takes 4 cycles and a triangle takes 8 cycles from acceptance to `primDone`.

**Output registration:** all outputs are registered except `cmd_ready` and `busy`, which are decoded from state.

## Test plan
1. **Line with clamping:** line v0=(0,0), v1=(640,480). Expect `positions` = {10'd0, 9'd0, 10'd639, 9'd479}, one `primSelect` pulse, then `primDone` one cycle after the `lineDone` rise.
2. **Triangle order:** triangle (10,10),(100,20),(50,200). Expect three `primSelect` pulses with `positions` (10,10,100,20), (100,20,50,200), (50,200,10,10), and `busy` high throughout.
3. **Rectangle order:** rectangle v0=(5,5), v1=(20,30), v2 arbitrary. Expect segments (5,5,20,5), (20,5,20,30), (20,30,5,30), (5,30,5,5).
4. **Reserved type and ignored commands:** reserved `cmd_type`=11 expects an `err` pulse, no `primSelect`, and `cmd_ready` still 1. Also, `cmd_valid` toggled while busy is ignored, so the latched vertices are unchanged.
5. **Level `lineDone`:** `lineDone` held high for 10 cycles during a triangle expects exactly one segment advance per rising edge.
6. **Reset mid-WAIT:** `n_rst` pulsed low in WAIT of segment 2 of a triangle expects all outputs at reset values immediately and no `primDone`. A new line command is then accepted normally.
